task3: RTL and testbench
========================

# task3

Single-step Simple RISC Machine (SRM) CPU with its own 256×16 program/data RAM.
- On each reset it loads its PC from `start_pc`, then fetches and executes exactly one instruction, then halts until the next reset.
- The register file and RAM keep their contents across resets, so a sequence of resets with different `start_pc` values runs a program one instruction at a time.
- `out` exposes the datapath result register C.

## Interface
No parameters.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_pc`  in  8  RAM address of the instruction to execute; sampled only while `rst_n`=0.
- `out`  out  16  datapath result register C.

## Operation
Internal state:
- R0–R7, 16-bit each; not cleared by reset.
- PC, 8-bit.
- IR, 16-bit.
- Operand registers A and B.
- C register (drives `out`).
- Status flags Z, N, V, written only by CMP.
- RAM: 256×16, synchronous read (1-cycle latency), synchronous write.

Instruction fields:
- [15:13] opcode, [12:11] op.
- Rn = [10:8], Rd = [7:5], sh = [4:3], Rm = [2:0].
- imm8 = [7:0], sign-extended to 16 bits.
- imm5 = [4:0], sign-extended to 16 bits.

Shifter applies to B only (sh field):
- 00: none.
- 01: LSL 1.
- 10: LSR 1, zero fill.
- 11: ASR 1.

Instructions:
- MOV Rn,#imm8 (110/10): Rn←sx(imm8). C is not loaded.
- MOV Rd,Rm,sh (110/00): C←sh(Rm); Rd←C.
- ADD (101/00): C←Rn+sh(Rm), modulo 2^16; Rd←C.
- CMP (101/01): computes Rn−sh(Rm) and sets Z, N, V (V = signed overflow). C and Rd are unchanged.
- AND (101/10): C←Rn & sh(Rm); Rd←C.
- MVN (101/11): C←~sh(Rm); Rd←C.
- LDR Rd,[Rn,#imm5] (011/00): C←Rn+sx(imm5); Rd←RAM[C[7:0]].
- STR Rd,[Rn,#imm5] (100/00):
  - address = Rn+sx(imm5), used for the write only, not latched in C;
  - then C←Rd via the shifter path with no shift;
  - RAM[address[7:0]]←C.
- HALT (111), and any undefined opcode/op combination: no register, C or RAM change.

After the instruction completes, the FSM enters HALT and stays there until `rst_n` is asserted again.

RAM initial image (hex; all other words 0000):
- 00 D105: MOV R1,#5
- 01 D207: MOV R2,#7
- 02 D207: MOV R2,#7
- 03 A162: ADD R3,R1,R2
- 04 B182: AND R4,R1,R2
- 05 B8A2: MVN R5,R2
- 06 62C4: LDR R6,[R2,#4]
- 07 61E5: LDR R7,[R1,#5]
- 08 81CA: STR R6,[R1,#10]
- 09 C0AE: MOV R5,R6,LSL#1
- 0A 0020: data
- 0B 0001: data
- 0C 61AA: LDR R5,[R1,#10]

## Timing
While `rst_n`=0 (asynchronous):
- PC←`start_pc`, tracking the input.
- C←0, so `out`=0.
- FSM goes to FETCH.
- R0–R7, flags and RAM are untouched.

After `rst_n` rises, the FSM steps one state per clock through:
- FETCH: RAM address = PC.
- LOAD_IR.
- DECODE.
- GET_A / GET_B as required by the instruction.
- EXEC.
- Then either WRITEBACK, or MEM_ADDR → MEM_RD/MEM_WR → WRITEBACK for memory instructions.
- Then HALT.

Latency and output rules:
- Worst case is at most 10 clocks from reset release to entering HALT.
- `out` changes only on the EXEC-cycle clock edge (on the STR data-path cycle for STR), and stays stable in HALT.
- `start_pc` changes while `rst_n`=1 have no effect.

Reset asserted mid-instruction:
- Aborts immediately.
- Any register or RAM write not yet clocked is discarded.
- Writes completed earlier persist.

Arithmetic wraps at 16 bits. RAM addresses use bits [7:0] of the computed address.

## Test plan
Each step: set `start_pc`, hold `rst_n` low for 1 clock, release, wait 20 clocks, check `out`. Run the steps in order; state carries over between steps.
- `start_pc`=0, then `start_pc`=2 → `out`=0000 after each; R1=5, R2=7.
- `start_pc`=3 → `out`=000C (12). Then `start_pc`=4 → `out`=0005. Then `start_pc`=5 → `out`=FFF8.
- `start_pc`=6 → `out`=000B (R6=1). Then `start_pc`=7 → `out`=000A (R7=0x20).
- `start_pc`=8 → `out`=0001 and RAM[0x0F]=1. Then `start_pc`=9 → `out`=0002.
- `start_pc`=12 → `out`=000F (R5=1, read back from the STR result).
- Reset asserted in the middle of the ADD at address 3 → `out`=0 immediately and R3 is unchanged; after release the ADD completes normally.

Source files
------------

// File: rtl/task3.sv
// Single-step SRM CPU: on each reset release it fetches and executes the one
// instruction at start_pc, then halts. Register file and RAM survive resets.
module task3 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  start_pc,
    output logic [15:0] out
);
    typedef enum logic [3:0] {
        S_FETCH, S_LOAD_IR, S_DECODE, S_GET_A, S_GET_B, S_EXEC,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WRITEBACK, S_HALT
    } state_t;

    typedef logic [15:0] mem_t [0:255];

    function automatic mem_t init_image();
        mem_t m;
        for (int i = 0; i < 256; i++) m[i] = 16'h0000;
        m[8'h00] = 16'hD105;
        m[8'h01] = 16'hD207;
        m[8'h02] = 16'hD207;
        m[8'h03] = 16'hA162;
        m[8'h04] = 16'hB182;
        m[8'h05] = 16'hB8A2;
        m[8'h06] = 16'h62C4;
        m[8'h07] = 16'h61E5;
        m[8'h08] = 16'h81CA;
        m[8'h09] = 16'hC0AE;
        m[8'h0A] = 16'h0020;
        m[8'h0B] = 16'h0001;
        m[8'h0C] = 16'h61AA;
        return m;
    endfunction

    logic [15:0] mem_q [0:255] = init_image();
    logic [15:0] rf_q  [0:7];

    state_t      state_q, state_d;
    logic [7:0]  pc_q;
    logic [15:0] ir_q, ir_d;
    logic [15:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [7:0]  mar_q, mar_d;
    logic        z_q, z_d, n_q, n_d, v_q, v_d;
    logic [15:0] ram_rdata_q;

    logic [7:0]  ram_addr_s;
    logic        ram_we_s;
    logic        rf_we_s;
    logic [2:0]  rf_waddr_s;
    logic [15:0] rf_wdata_s;

    logic [2:0]  opcode_s, rn_s, rd_s, rm_s;
    logic [1:0]  op_s, sh_s;
    logic [15:0] sx8_s, sx5_s, b_sh_s, sum_s, diff_s, addr_sum_s;
    logic        is_movi_s, is_movr_s, is_alu_s, is_ldr_s, is_str_s;
    logic        valid_s, needs_a_s, needs_b_s;

    assign opcode_s   = ir_q[15:13];
    assign op_s       = ir_q[12:11];
    assign rn_s       = ir_q[10:8];
    assign rd_s       = ir_q[7:5];
    assign sh_s       = ir_q[4:3];
    assign rm_s       = ir_q[2:0];
    assign sx8_s      = {{8{ir_q[7]}}, ir_q[7:0]};
    assign sx5_s      = {{11{ir_q[4]}}, ir_q[4:0]};

    assign is_movi_s  = (opcode_s == 3'b110) && (op_s == 2'b10);
    assign is_movr_s  = (opcode_s == 3'b110) && (op_s == 2'b00);
    assign is_alu_s   = (opcode_s == 3'b101);
    assign is_ldr_s   = (opcode_s == 3'b011) && (op_s == 2'b00);
    assign is_str_s   = (opcode_s == 3'b100) && (op_s == 2'b00);
    assign valid_s    = is_movi_s | is_movr_s | is_alu_s | is_ldr_s | is_str_s;
    assign needs_a_s  = is_alu_s | is_ldr_s | is_str_s;
    assign needs_b_s  = is_movr_s | is_alu_s | is_str_s;

    // Shifter on the B operand
    always_comb begin
        case (sh_s)
            2'b00:   b_sh_s = b_q;
            2'b01:   b_sh_s = {b_q[14:0], 1'b0};
            2'b10:   b_sh_s = {1'b0, b_q[15:1]};
            2'b11:   b_sh_s = {b_q[15], b_q[15:1]};
            default: b_sh_s = b_q;
        endcase
    end

    assign sum_s      = a_q + b_sh_s;
    assign diff_s     = a_q - b_sh_s;
    assign addr_sum_s = a_q + sx5_s;
    assign out        = c_q;

    // Next-state, datapath register updates and write strobes
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        mar_d      = mar_q;
        z_d        = z_q;
        n_d        = n_q;
        v_d        = v_q;
        ram_we_s   = 1'b0;
        rf_we_s    = 1'b0;
        rf_waddr_s = 3'd0;
        rf_wdata_s = 16'h0000;
        ram_addr_s = (state_q == S_FETCH) ? pc_q : mar_q;
        case (state_q)
            S_FETCH:   state_d = S_LOAD_IR;
            S_LOAD_IR: begin
                ir_d    = ram_rdata_q;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (!valid_s)       state_d = S_HALT;
                else if (needs_a_s) state_d = S_GET_A;
                else if (needs_b_s) state_d = S_GET_B;
                else                state_d = S_EXEC;
            end
            S_GET_A: begin
                a_d     = rf_q[rn_s];
                state_d = needs_b_s ? S_GET_B : S_EXEC;
            end
            S_GET_B: begin
                // STR routes the store data (Rd) through B
                b_d     = is_str_s ? rf_q[rd_s] : rf_q[rm_s];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_movr_s) begin
                    c_d = b_sh_s;
                end else if (is_alu_s) begin
                    case (op_s)
                        2'b00: c_d = sum_s;
                        2'b01: begin
                            z_d = (diff_s == 16'h0000);
                            n_d = diff_s[15];
                            v_d = (a_q[15] != b_sh_s[15]) && (diff_s[15] != a_q[15]);
                        end
                        2'b10: c_d = a_q & b_sh_s;
                        2'b11: c_d = ~b_sh_s;
                        default: c_d = c_q;
                    endcase
                end else if (is_ldr_s) begin
                    c_d   = addr_sum_s;
                    mar_d = addr_sum_s[7:0];
                end else if (is_str_s) begin
                    mar_d = addr_sum_s[7:0];
                end else begin
                    c_d = c_q;
                end
                state_d = (is_ldr_s | is_str_s) ? S_MEM_ADDR : S_WRITEBACK;
            end
            S_MEM_ADDR: begin
                if (is_str_s) begin
                    c_d     = b_q;
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD:  state_d = S_WRITEBACK;
            S_MEM_WR: begin
                ram_we_s = 1'b1;
                state_d  = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                if (is_movi_s) begin
                    rf_we_s    = 1'b1;
                    rf_waddr_s = rn_s;
                    rf_wdata_s = sx8_s;
                end else if (is_ldr_s) begin
                    rf_we_s    = 1'b1;
                    rf_waddr_s = rd_s;
                    rf_wdata_s = ram_rdata_q;
                end else if (is_movr_s || (is_alu_s && (op_s != 2'b01))) begin
                    rf_we_s    = 1'b1;
                    rf_waddr_s = rd_s;
                    rf_wdata_s = c_q;
                end else begin
                    rf_we_s    = 1'b0;
                end
                state_d = S_HALT;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Control state, PC and result register; reset aborts the instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= start_pc;
            c_q     <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_q;
            c_q     <= c_d;
        end
    end

    // Architectural state that survives reset
    always_ff @(posedge clk) begin
        ir_q  <= ir_d;
        a_q   <= a_d;
        b_q   <= b_d;
        mar_q <= mar_d;
        z_q   <= z_d;
        n_q   <= n_d;
        v_q   <= v_d;
    end

    // Register file, RAM write port and registered RAM read
    always_ff @(posedge clk) begin
        if (rf_we_s) rf_q[rf_waddr_s] <= rf_wdata_s;
        if (ram_we_s) mem_q[mar_q] <= c_q;
        ram_rdata_q <= mem_q[ram_addr_s];
    end
endmodule

// File: tb/tb_task3.sv
// Directed bench for task3: steps the RAM program one instruction per reset
// and checks the C register output against hand-computed values.
module tb_task3;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  start_pc = 8'h00;
    logic [15:0] out;
    int          checks = 0;
    int          passed = 0;

    task3 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_pc (start_pc),
        .out      (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] exp);
        checks++;
        assert (out === exp) passed++;
        else $error("FAIL %s: out=%h expected %h", tag, out, exp);
    endtask

    task automatic run_step(input logic [7:0] pc);
        @(negedge clk);
        start_pc = pc;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        run_step(8'h00);
        chk("mov_r1_imm", 16'h0000);
        run_step(8'h02);
        chk("mov_r2_imm", 16'h0000);
        run_step(8'h03);
        chk("add_r3", 16'h000C);

        // out clears asynchronously; AND result cannot appear before EXEC
        @(negedge clk);
        start_pc = 8'h04;
        rst_n    = 1'b0;
        #1 chk("reset_clears_out", 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("and_before_exec", 16'h0000);
        repeat (17) @(negedge clk);
        chk("and_r4", 16'h0005);

        run_step(8'h05);
        chk("mvn_r5", 16'hFFF8);
        run_step(8'h06);
        chk("ldr_r6", 16'h000B);
        run_step(8'h07);
        chk("ldr_r7", 16'h000A);
        run_step(8'h08);
        chk("str_r6", 16'h0001);

        // start_pc moves while running: must be ignored; out stable in HALT
        @(negedge clk);
        start_pc = 8'h09;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        start_pc = 8'h03;
        repeat (10) @(negedge clk);
        chk("mov_lsl_early", 16'h0002);
        repeat (10) @(negedge clk);
        chk("mov_lsl_halt", 16'h0002);

        run_step(8'h0C);
        chk("ldr_str_readback", 16'h000F);
        run_step(8'h0D);
        chk("undefined_op", 16'h0000);

        // Abort the ADD at address 3 just after its EXEC edge
        @(negedge clk);
        start_pc = 8'h03;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("add_pre_exec", 16'h0000);
        @(negedge clk);
        chk("add_exec_edge", 16'h000C);
        rst_n = 1'b0;
        #1 chk("abort_out_zero", 16'h0000);
        @(negedge clk);
        chk("abort_held", 16'h0000);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("add_resume", 16'h000C);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
